// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared FSM type, parameter defaults and clog2 helper for the write arbiter
package fifo_wr_arbiter_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int FIFO_DWTH_DEF = 8;
  localparam int MAX_BURST_DEF = 16;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set search starting at ptr with wrap-around
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k >= NUM_REQ) ? int'(ptr) + k - NUM_REQ : int'(ptr) + k);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding the write side of a sync FIFO
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int FIFO_DWTH = FIFO_DWTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int IW = clog2(NUM_REQ),
  localparam int CW = clog2(MAX_BURST + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*FIFO_DWTH-1:0] req_data,
  input  logic                         fifo_full,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         fifo_wren,
  output logic [FIFO_DWTH-1:0]         fifo_din,
  output logic                         busy,
  output logic [IW-1:0]                owner_id
);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pick_found, accept, done;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .found(pick_found),
    .idx(pick_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    accept = !rst && state_q == GRANT && req[owner_q] && !fifo_full;
    done = state_q == GRANT && (!req[owner_q] ||
           (accept && (req_last[owner_q] || cnt_q == CW'(MAX_BURST - 1))));
    state_d = done ? IDLE : (state_q == IDLE && pick_found) ? GRANT : state_q;
    owner_d = (state_q == IDLE && pick_found) ? pick_idx : owner_q;
    cnt_d = (state_q == IDLE) ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    ptr_d = !done ? ptr_q : (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    gnt = accept ? NUM_REQ'(1) << owner_q : '0;
    fifo_wren = accept;
    fifo_din = req_data[owner_q*FIFO_DWTH +: FIFO_DWTH];
    busy = state_q == GRANT;
    owner_id = owner_q;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and random run against a burst-level model
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic rst, fifo_full, fifo_wren, busy;
  logic [N-1:0] req, req_last, gnt;
  logic [N*W-1:0] req_data;
  logic [W-1:0] fifo_din;
  logic [1:0] owner_id;
  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [7:0] dconst [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] last;
    logic full;
    logic [3:0] gnt;
    logic busy;
    logic [1:0] owner;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_DWTH(W), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_last(req_last),
    .req_data(req_data),
    .fifo_full(fifo_full),
    .gnt(gnt),
    .fifo_wren(fifo_wren),
    .fifo_din(fifo_din),
    .busy(busy),
    .owner_id(owner_id)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] lst, logic f,
                              logic [3:0] g, logic b, logic [1:0] o);
    vec_t v;
    v.rst = r; v.req = rq; v.last = lst; v.full = f; v.gnt = g; v.busy = b; v.owner = o;
    return v;
  endfunction
  task automatic apply(input vec_t v, input string name);
    rst = v.rst; req = v.req; req_last = v.last; fifo_full = v.full;
    @(negedge clk);
    chk({name, ".gnt"}, 32'(gnt), 32'(v.gnt));
    chk({name, ".wren"}, 32'(fifo_wren), 32'(|v.gnt));
    chk({name, ".busy"}, 32'(busy), 32'(v.busy));
    chk({name, ".owner"}, 32'(owner_id), 32'(v.owner));
    if (|v.gnt) chk({name, ".din"}, 32'(fifo_din), 32'(dconst[v.owner]));
    if (fifo_wren === 1'b1) wr_cnt++;
    @(posedge clk);
    #1;
  endtask
  bit act [N];
  int seq [N];
  bit m_busy;
  int m_owner, m_cnt, m_ptr;
  logic [3:0] exp_g, seen_g;
  initial begin
    rst = 1'b1; req = '0; req_last = '0; fifo_full = 1'b0;
    req_data = {dconst[3], dconst[2], dconst[1], dconst[0]};
    repeat (2) @(posedge clk);
    #1;
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2));
    tbl.push_back(mk(0, 4'b1011, 4'b0000, 0, 4'b0000, 0, 2));
    tbl.push_back(mk(0, 4'b1011, 4'b1000, 0, 4'b1000, 1, 3));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 3));
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));
    apply(mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 3), "maxb.idle");
    for (int i = 0; i < MB; i++) apply(mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1), $sformatf("maxb.b%0d", i + 1));
    apply(mk(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 1), "maxb.gap");
    apply(mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1), "maxb.regrant");
    apply(mk(0, 4'b0011, 4'b0000, 0, 4'b0000, 0, 1), "maxb.ptr2");
    apply(mk(0, 4'b0011, 4'b0001, 0, 4'b0001, 1, 0), "maxb.pick0");
    wr_cnt = 0;
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0), "full.idle");
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0), "full.b1");
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0), "full.b2");
    for (int i = 0; i < 5; i++) apply(mk(0, 4'b0001, (i >= 3) ? 4'b0001 : 4'b0000, 1, 4'b0000, 1, 0), $sformatf("full.stall%0d", i));
    apply(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 0), "full.b3");
    apply(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0), "full.exit");
    chk("full.beats", 32'(wr_cnt), 32'd3);
    apply(mk(0, 4'b1001, 4'b0000, 0, 4'b0000, 0, 0), "drop.idle");
    apply(mk(0, 4'b1001, 4'b0000, 0, 4'b1000, 1, 3), "drop.b1");
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 1, 3), "drop.abandon");
    apply(mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 3), "drop.gap");
    apply(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 0), "drop.next0");
    wr_cnt = 0;
    apply(mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0), "rst.idle");
    for (int i = 0; i < 3; i++) apply(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2), $sformatf("rst.b%0d", i + 1));
    apply(mk(1, 4'b0100, 4'b0000, 0, 4'b0000, 1, 2), "rst.b4");
    apply(mk(0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0), "rst.after");
    chk("rst.beats", 32'(wr_cnt), 32'd3);
    apply(mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 1, 0), "rst.ptr0");
    apply(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0), "rnd.rst");
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin act[i] = 0; seq[i] = 0; end
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        act[i] = act[i] ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) == 0);
        req[i] = act[i];
        req_last[i] = ($urandom_range(0, 7) == 0);
        req_data[i*W +: W] = 8'(i * 64 + seq[i] % 64);
      end
      @(negedge clk);
      exp_g = (m_busy && !rst && req[m_owner] && !fifo_full) ? 4'(1 << m_owner) : 4'b0000;
      chk("rnd.gnt", 32'(gnt), 32'(exp_g));
      chk("rnd.wren", 32'(fifo_wren), 32'(|exp_g));
      chk("rnd.busy", 32'(busy), 32'(m_busy));
      chk("rnd.owner", 32'(owner_id), 32'(m_owner));
      if (|exp_g) chk("rnd.din", 32'(fifo_din), 32'(m_owner * 64 + seq[m_owner] % 64));
      seen_g = gnt;
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      end else if (!m_busy) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) begin m_busy = 1; m_owner = (m_ptr + k) % N; m_cnt = 0; end
      end else begin
        if (|exp_g) m_cnt++;
        if ((|exp_g && (req_last[m_owner] || m_cnt == MB)) || !req[m_owner]) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) if (seen_g[i] === 1'b1) seq[i]++;
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
